// File: rtl/draw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : draw_pkg
// Purpose  : Shared encodings and default geometry for the drawing pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package draw_pkg;

    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 7;
    localparam int DEF_SIZE_W   = 5;
    localparam int DEF_COLOR_W  = 3;
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    localparam logic [1:0] FILL    = 2'b00;
    localparam logic [1:0] OUTLINE = 2'b01;
    localparam logic [1:0] ERASE   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_outline(input logic [1:0] m);
        return m == OUTLINE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/draw_scan_ctr.sv
`default_nettype none
// ============================================================================
// Module   : draw_scan_ctr
// Purpose  : Row-major cx/cy scan counter with look-ahead next position.
// Revision : 1.0 - initial release
// ============================================================================
module draw_scan_ctr #(
    parameter int SIZE_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    input  logic [SIZE_W-1:0] w,
    input  logic [SIZE_W-1:0] h,
    output logic [SIZE_W-1:0] cx,
    output logic [SIZE_W-1:0] cy,
    output logic [SIZE_W-1:0] cx_nxt,
    output logic [SIZE_W-1:0] cy_nxt,
    output logic              first,
    output logic              last_col,
    output logic              last_row,
    output logic              last
);

    logic [SIZE_W-1:0] r_cx;
    logic [SIZE_W-1:0] r_cy;

    assign cx = r_cx;
    assign cy = r_cy;

    always_comb begin
        first    = (r_cx == '0) && (r_cy == '0);
        last_col = (r_cx == w - SIZE_W'(1));
        last_row = (r_cy == h - SIZE_W'(1));
        last     = last_col && last_row;
        cx_nxt   = last_col ? '0 : r_cx + SIZE_W'(1);
        cy_nxt   = r_cy;
        if (last_col) begin
            cy_nxt = last_row ? '0 : r_cy + SIZE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (advance) begin
            r_cx <= cx_nxt;
            r_cy <= cy_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rect_blit.sv
`default_nettype none
// ============================================================================
// Module   : rect_blit
// Purpose  : Rectangle rasteriser (fill/outline/erase) with plot backpressure.
//            Define DRAW_CLIP_EN to suppress plots outside the visible screen.
// Revision : 1.0 - initial release
// ============================================================================
module rect_blit
    import draw_pkg::*;
#(
    parameter int                 X_W      = DEF_X_W,
    parameter int                 Y_W      = DEF_Y_W,
    parameter int                 SIZE_W   = DEF_SIZE_W,
    parameter int                 COLOR_W  = DEF_COLOR_W,
    parameter int                 SCREEN_W = DEF_SCREEN_W,
    parameter int                 SCREEN_H = DEF_SCREEN_H,
    parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [X_W-1:0]     x_in,
    input  logic [Y_W-1:0]     y_in,
    input  logic [SIZE_W-1:0]  width,
    input  logic [SIZE_W-1:0]  height,
    input  logic [COLOR_W-1:0] c_in,
    input  logic [1:0]         mode,
    input  logic               plot_ready,
    output logic [X_W-1:0]     x_out,
    output logic [Y_W-1:0]     y_out,
    output logic [COLOR_W-1:0] c_out,
    output logic               plot,
    output logic               busy,
    output logic               done
);

    localparam logic [X_W:0] c_screen_w = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] c_screen_h = (Y_W+1)'(SCREEN_H);

    state_t             r_state;
    logic [X_W-1:0]     r_x0;
    logic [Y_W-1:0]     r_y0;
    logic [SIZE_W-1:0]  r_w;
    logic [SIZE_W-1:0]  r_h;
    logic [1:0]         r_mode;
    logic [X_W-1:0]     r_x_out;
    logic [Y_W-1:0]     r_y_out;
    logic [COLOR_W-1:0] r_c_out;
    logic               r_plot;
    logic               r_busy;
    logic               r_done;

    logic               w_clear;
    logic               w_advance;
    logic [SIZE_W-1:0]  w_cx;
    logic [SIZE_W-1:0]  w_cy;
    logic [SIZE_W-1:0]  w_cx_nxt;
    logic [SIZE_W-1:0]  w_cy_nxt;
    logic               w_first;
    logic               w_last_col;
    logic               w_last_row;
    logic               w_last;

    logic [X_W-1:0]     w_sel_x0;
    logic [Y_W-1:0]     w_sel_y0;
    logic [SIZE_W-1:0]  w_sel_w;
    logic [SIZE_W-1:0]  w_sel_h;
    logic [SIZE_W-1:0]  w_sel_cx;
    logic [SIZE_W-1:0]  w_sel_cy;
    logic [1:0]         w_sel_mode;
    logic [X_W:0]       w_ux;
    logic [Y_W:0]       w_uy;
    logic               w_edge;
    logic               w_in_screen;
    logic               w_pix_plot;
    logic [COLOR_W-1:0] w_color_in;

    assign w_clear   = (r_state == IDLE) && start;
    assign w_advance = (r_state == RUN) && plot_ready;

    draw_scan_ctr #(
        .SIZE_W (SIZE_W)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_clear),
        .advance  (w_advance),
        .w        (r_w),
        .h        (r_h),
        .cx       (w_cx),
        .cy       (w_cy),
        .cx_nxt   (w_cx_nxt),
        .cy_nxt   (w_cy_nxt),
        .first    (w_first),
        .last_col (w_last_col),
        .last_row (w_last_row),
        .last     (w_last)
    );

    // The output registers always load the pixel that will be shown after the
    // coming edge: the origin on start, otherwise the counter's next position.
    always_comb begin
        if (r_state == IDLE) begin
            w_sel_x0   = x_in;
            w_sel_y0   = y_in;
            w_sel_w    = width;
            w_sel_h    = height;
            w_sel_mode = mode;
            w_sel_cx   = '0;
            w_sel_cy   = '0;
        end else begin
            w_sel_x0   = r_x0;
            w_sel_y0   = r_y0;
            w_sel_w    = r_w;
            w_sel_h    = r_h;
            w_sel_mode = r_mode;
            w_sel_cx   = w_cx_nxt;
            w_sel_cy   = w_cy_nxt;
        end
    end

    assign w_ux   = {1'b0, w_sel_x0} + (X_W+1)'(w_sel_cx);
    assign w_uy   = {1'b0, w_sel_y0} + (Y_W+1)'(w_sel_cy);
    assign w_edge = (w_sel_cx == '0) || (w_sel_cx == w_sel_w - SIZE_W'(1)) ||
                    (w_sel_cy == '0) || (w_sel_cy == w_sel_h - SIZE_W'(1));

`ifdef DRAW_CLIP_EN
    assign w_in_screen = (w_ux < c_screen_w) && (w_uy < c_screen_h);
`else
    // Coordinates wrap, so the carry bits and screen bounds go unused here.
    assign w_in_screen = 1'b1;
    logic w_unused_clip;
    assign w_unused_clip = &{1'b0, w_ux[X_W], w_uy[Y_W], c_screen_w, c_screen_h};
`endif

    assign w_pix_plot = (is_outline(w_sel_mode) ? w_edge : 1'b1) && w_in_screen;
    assign w_color_in = (mode == ERASE) ? BG_COLOR : c_in;

    logic w_unused_ctr;
    assign w_unused_ctr = &{1'b0, w_cx, w_cy, w_first, w_last_col, w_last_row};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_x0    <= '0;
            r_y0    <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_mode  <= FILL;
            r_x_out <= '0;
            r_y_out <= '0;
            r_c_out <= '0;
            r_plot  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_x0   <= x_in;
                        r_y0   <= y_in;
                        r_w    <= width;
                        r_h    <= height;
                        r_mode <= mode;
                        if (width == '0 || height == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                            r_x_out <= w_ux[X_W-1:0];
                            r_y_out <= w_uy[Y_W-1:0];
                            r_c_out <= w_color_in;
                            r_plot  <= w_pix_plot;
                        end
                    end
                end
                RUN: begin
                    if (plot_ready) begin
                        if (w_last) begin
                            r_state <= DONE;
                            r_plot  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_x_out <= w_ux[X_W-1:0];
                            r_y_out <= w_uy[Y_W-1:0];
                            r_plot  <= w_pix_plot;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign x_out = r_x_out;
    assign y_out = r_y_out;
    assign c_out = r_c_out;
    assign plot  = r_plot;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rect_blit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rect_blit
// Purpose  : Directed table-driven bench for rect_blit plus corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rect_blit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] x_in = '0;
    logic [6:0] y_in = '0;
    logic [4:0] width = '0;
    logic [4:0] height = '0;
    logic [2:0] c_in = '0;
    logic [1:0] mode = '0;
    logic       plot_ready = 1'b1;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] c_out;
    logic       plot;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    rect_blit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .x_in       (x_in),
        .y_in       (y_in),
        .width      (width),
        .height     (height),
        .c_in       (c_in),
        .mode       (mode),
        .plot_ready (plot_ready),
        .x_out      (x_out),
        .y_out      (y_out),
        .c_out      (c_out),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int w;
        int h;
        int c;
        int m;
        int ecol;
        int eplots;
        int edone;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_start(input int x, input int y, input int w, input int h,
                               input int c, input int m);
        @(negedge clk);
        x_in   = 8'(x);
        y_in   = 7'(y);
        width  = 5'(w);
        height = 5'(h);
        c_in   = 3'(c);
        mode   = 2'(m);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        // scramble inputs to show only the captured values matter
        x_in   = 8'd77;
        y_in   = 7'd33;
        width  = 5'd9;
        height = 5'd9;
        c_in   = 3'd1;
        mode   = 2'b01;
    endtask

    task automatic run_vec(input vec_t v);
        int n, plots, done_at, cx, cy, ux, uy;
        bit ep;
        n = 0; plots = 0; done_at = 0;
        plot_ready = 1'b1;
        drive_start(v.x, v.y, v.w, v.h, v.c, v.m);
        for (int k = 1; k <= 300 && done_at == 0; k++) begin
            if (done) begin
                done_at = k;
                chk("busy_at_done", int'(busy), 0);
                chk("plot_at_done", int'(plot), 0);
            end else begin
                cx = (v.w > 0) ? n % v.w : 0;
                cy = (v.w > 0) ? n / v.w : 0;
                ux = v.x + cx;
                uy = v.y + cy;
                ep = (v.m == 1) ? (cx == 0 || cx == v.w - 1 || cy == 0 || cy == v.h - 1) : 1'b1;
`ifdef DRAW_CLIP_EN
                if (ux >= 160 || uy >= 120) ep = 1'b0;
`endif
                chk("busy_run", int'(busy), 1);
                chk("x_out", int'(x_out), ux % 256);
                chk("y_out", int'(y_out), uy % 128);
                chk("plot", int'(plot), int'(ep));
                if (ep) chk("c_out", int'(c_out), v.ecol);
                plots += int'(plot);
                n++;
                @(negedge clk);
            end
        end
        chk("done_cycle", done_at, v.edone);
        chk("plot_count", plots, v.eplots);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int idx, done_at, dones, busies;

        //          x    y    w  h  c  m  ecol plots done
        vecs[0] = '{10,  20,  3, 2, 5, 0, 5,   6,    7};
        vecs[1] = '{0,   0,   4, 3, 3, 1, 3,   10,   13};
        vecs[2] = '{5,   5,   2, 2, 7, 2, 0,   4,    5};
`ifdef DRAW_CLIP_EN
        vecs[3] = '{158, 0,   4, 1, 1, 0, 1,   2,    5};
        vecs[5] = '{250, 126, 2, 3, 6, 3, 6,   0,    7};
`else
        vecs[3] = '{158, 0,   4, 1, 1, 0, 1,   4,    5};
        vecs[5] = '{250, 126, 2, 3, 6, 3, 6,   6,    7};
`endif
        vecs[4] = '{30,  40,  0, 3, 2, 0, 2,   0,    1};
        vecs[6] = '{30,  40,  5, 0, 2, 0, 2,   0,    1};
        vecs[7] = '{9,   9,   1, 1, 4, 1, 4,   1,    2};
        vecs[8] = '{1,   2,   3, 3, 6, 1, 6,   8,    10};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_x_out", int'(x_out), 0);
        chk("rst_y_out", int'(y_out), 0);
        chk("rst_c_out", int'(c_out), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // backpressure: 2x2 fill at (3,4) with ready pattern 1,0,0,1,1,0,1
        drive_start(3, 4, 2, 2, 2, 0);
        idx = 0; done_at = 0;
        for (int k = 1; k <= 30 && done_at == 0; k++) begin
            if (done) begin
                done_at = k;
                chk("bp_accepts", idx, 4);
            end else begin
                chk("bp_x", int'(x_out), 3 + idx % 2);
                chk("bp_y", int'(y_out), 4 + idx / 2);
                chk("bp_plot", int'(plot), 1);
                chk("bp_c", int'(c_out), 2);
                plot_ready = (k <= 7) ? pat[k-1] : 1'b1;
                if (plot_ready) idx++;
                @(negedge clk);
            end
        end
        chk("bp_done_cycle", done_at, 8);
        plot_ready = 1'b1;

        // start during RUN and during DONE: both ignored, nothing queued
        drive_start(0, 0, 3, 1, 4, 0);
        done_at = 0;
        for (int k = 1; k <= 30 && done_at == 0; k++) begin
            if (done) begin
                done_at = k;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end else begin
                chk("ign_x", int'(x_out), k - 1);
                chk("ign_y", int'(y_out), 0);
                start = (k == 2);
                x_in  = 8'd50;
                width = 5'd1;
                @(negedge clk);
            end
        end
        chk("ign_done_cycle", done_at, 4);
        chk("ign_busy_after", int'(busy), 0);
        @(negedge clk);
        chk("ign_busy_after2", int'(busy), 0);
        chk("ign_done_after2", int'(done), 0);

        // reset in the middle of a 5x5 draw
        drive_start(20, 30, 5, 5, 6, 0);
        repeat (6) @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_x_out", int'(x_out), 0);
        chk("mrst_y_out", int'(y_out), 0);
        chk("mrst_c_out", int'(c_out), 0);
        chk("mrst_plot", int'(plot), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        reset = 1'b1;
        dones = 0; busies = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            dones  += int'(done);
            busies += int'(busy);
        end
        chk("mrst_no_done", dones, 0);
        chk("mrst_no_busy", busies, 0);

        // fresh transaction after the abandoned one
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
